// File: rtl/anim_frame_sequencer.sv
// Animation frame sequencer for the goose sprite renderer.
// Steps the sprite frame index once per programmable number of video frames.
module anim_frame_sequencer #(
    parameter int NUM_FRAMES   = 4,
    parameter int FRAME_W      = 2,
    parameter int CNT_W        = 6,
    parameter int DEFAULT_HOLD = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic [CNT_W-1:0]   hold_cfg,
    input  logic               pingpong,
    input  logic               pause,
    input  logic               step_req,
    output logic [FRAME_W-1:0] frame_num,
    output logic               frame_adv,
    output logic               dir,
    output logic               sof
);

    typedef enum logic {RUN, PAUSED} state_t;

    localparam logic [FRAME_W-1:0] LAST   = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] F_ONE  = FRAME_W'(1);
    localparam logic [FRAME_W:0]   LIMIT  = (FRAME_W+1)'(NUM_FRAMES);
    localparam logic [CNT_W-1:0]   C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   C_DEF  = CNT_W'(DEFAULT_HOLD);

    logic [1:0]         pause_sync_q;
    logic [1:0]         step_sync_q;
    logic [1:0]         pp_sync_q;
    logic [CNT_W-1:0]   hold_s1_q;
    logic [CNT_W-1:0]   hold_s2_q;
    logic               step_prev_q;
    logic               origin_q;
    logic               sof_q;
    logic               adv_q;
    logic               dir_q;
    logic               step_pend_q;
    logic [FRAME_W-1:0] frame_q;
    logic [CNT_W-1:0]   cnt_q;
    state_t             state_q;

    logic               pause_s;
    logic               step_s;
    logic               pp_s;
    logic               at_origin;
    logic               step_edge;
    logic [CNT_W-1:0]   hold_eff;
    logic               hold_hit;
    logic [FRAME_W-1:0] frame_d;
    logic               dir_d;

    assign pause_s   = pause_sync_q[1];
    assign step_s    = step_sync_q[1];
    assign pp_s      = pp_sync_q[1];
    assign at_origin = (pix_x == 10'd0) && (pix_y == 10'd0);
    assign step_edge = step_s && !step_prev_q;
    assign hold_eff  = (hold_s2_q == '0) ? C_DEF : hold_s2_q;
    assign hold_hit  = cnt_q >= (hold_eff - C_ONE);

    // Synchronisers run regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_sync_q <= '0;
            step_sync_q  <= '0;
            pp_sync_q    <= '0;
            hold_s1_q    <= '0;
            hold_s2_q    <= '0;
            step_prev_q  <= 1'b0;
        end else begin
            pause_sync_q <= {pause_sync_q[0], pause};
            step_sync_q  <= {step_sync_q[0], step_req};
            pp_sync_q    <= {pp_sync_q[0], pingpong};
            hold_s1_q    <= hold_cfg;
            hold_s2_q    <= hold_s1_q;
            step_prev_q  <= step_s;
        end
    end

    always_comb begin
        frame_d = '0;
        dir_d   = 1'b0;
        if ({1'b0, frame_q} >= LIMIT) begin
            frame_d = '0;
        end else if (!pp_s) begin
            frame_d = (frame_q == LAST) ? '0 : frame_q + F_ONE;
        end else if (!dir_q) begin
            if (frame_q == LAST) begin
                frame_d = LAST - F_ONE;
                dir_d   = 1'b1;
            end else begin
                frame_d = frame_q + F_ONE;
            end
        end else begin
            if (frame_q == '0) begin
                frame_d = F_ONE;
            end else begin
                frame_d = frame_q - F_ONE;
                dir_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_q    <= 1'b0;
            sof_q       <= 1'b0;
            adv_q       <= 1'b0;
            dir_q       <= 1'b0;
            step_pend_q <= 1'b0;
            frame_q     <= '0;
            cnt_q       <= '0;
            state_q     <= RUN;
        end else begin
            origin_q <= at_origin;
            sof_q    <= ena && at_origin && !origin_q;
            adv_q    <= 1'b0;
            if (ena) begin
                state_q <= pause_s ? PAUSED : RUN;
                if (!pp_s) dir_q <= 1'b0;
                case (state_q)
                    RUN: begin
                        step_pend_q <= 1'b0;
                        if (sof_q) begin
                            if (hold_hit) begin
                                cnt_q   <= '0;
                                frame_q <= frame_d;
                                dir_q   <= dir_d;
                                adv_q   <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + C_ONE;
                            end
                        end
                    end
                    PAUSED: begin
                        if (sof_q && step_pend_q) begin
                            cnt_q       <= '0;
                            frame_q     <= frame_d;
                            dir_q       <= dir_d;
                            adv_q       <= 1'b1;
                            step_pend_q <= 1'b0;
                        end else if (step_edge) begin
                            step_pend_q <= 1'b1;
                        end
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end

    assign frame_num = frame_q;
    assign frame_adv = adv_q;
    assign dir       = dir_q;
    assign sof       = sof_q;

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed bench for anim_frame_sequencer.
// Video frames are emulated by driving pix_x/pix_y to the origin briefly.
module tb_anim_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [5:0] hold_cfg;
    logic       pingpong;
    logic       pause;
    logic       step_req;
    logic [1:0] frame_num;
    logic       frame_adv;
    logic       dir;
    logic       sof;

    int checks = 0;
    int errors = 0;

    anim_frame_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .pix_x(pix_x), .pix_y(pix_y),
        .hold_cfg(hold_cfg), .pingpong(pingpong),
        .pause(pause), .step_req(step_req),
        .frame_num(frame_num), .frame_adv(frame_adv),
        .dir(dir), .sof(sof)
    );

    always #5 clk = ~clk;

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        settle(2);
        rst_n = 1'b1;
        settle(6);
    endtask

    // One video frame: origin for org_len cycles, then away from it.
    task automatic vframe(input int org_len, output int ns, output int na);
        ns = 0;
        na = 0;
        pix_x = 10'd0;
        pix_y = 10'd0;
        for (int i = 0; i < org_len + 4; i++) begin
            @(negedge clk);
            if (sof) ns++;
            if (frame_adv) na++;
            if (i == org_len - 1) begin
                pix_x = 10'd100;
                pix_y = 10'd7;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        settle(2);
        checks++;
        if ({frame_num, dir, frame_adv, sof} !== 5'b0) begin
            errors++;
            $display("FAIL reset_vals: got %b want 00000",
                     {frame_num, dir, frame_adv, sof});
        end
        rst_n = 1'b1;
        settle(6);
    endtask

    task automatic test_forward();
        int ns, na;
        logic [1:0] ef;
        for (int i = 1; i <= 45; i++) begin
            vframe(1, ns, na);
            ef = 2'((i / 10) % 4);
            checks++;
            if (ns !== 1) begin
                errors++;
                $display("FAIL fwd_sof f%0d: got %0d want 1", i, ns);
            end
            checks++;
            if (na !== ((i % 10 == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL fwd_adv f%0d: got %0d", i, na);
            end
            checks++;
            if (frame_num !== ef || dir !== 1'b0) begin
                errors++;
                $display("FAIL fwd_frame f%0d: got %0d/%b want %0d/0",
                         i, frame_num, dir, ef);
            end
        end
    endtask

    task automatic test_pingpong();
        int ns, na;
        logic [1:0] fseq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        logic       dseq [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        hold_cfg = 6'd2;
        pingpong = 1'b1;
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            vframe(1, ns, na);
            checks++;
            if (na !== ((i % 2 == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL pp_adv f%0d: got %0d", i, na);
            end
            checks++;
            if (frame_num !== fseq[i/2] || dir !== dseq[i/2]) begin
                errors++;
                $display("FAIL pp_seq f%0d: got %0d/%b want %0d/%b",
                         i, frame_num, dir, fseq[i/2], dseq[i/2]);
            end
        end
    endtask

    task automatic test_pause_step();
        int ns, na, tot;
        hold_cfg = 6'd0;
        pingpong = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) vframe(1, ns, na);
        pause = 1'b1;
        settle(6);
        for (int k = 0; k < 3; k++) begin
            step_req = 1'b1;
            settle(4);
            step_req = 1'b0;
            settle(4);
        end
        vframe(1, ns, na);
        checks++;
        if (na !== 1 || frame_num !== 2'd1) begin
            errors++;
            $display("FAIL step_adv: got adv %0d frame %0d want 1/1",
                     na, frame_num);
        end
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            vframe(1, ns, na);
            tot += na;
        end
        checks++;
        if (tot !== 0 || frame_num !== 2'd1) begin
            errors++;
            $display("FAIL pause_hold: got adv %0d frame %0d want 0/1",
                     tot, frame_num);
        end
        pause = 1'b0;
        settle(6);
        tot = 0;
        for (int i = 0; i < 9; i++) begin
            vframe(1, ns, na);
            tot += na;
        end
        checks++;
        if (tot !== 0) begin
            errors++;
            $display("FAIL resume_early: got adv %0d want 0", tot);
        end
        vframe(1, ns, na);
        checks++;
        if (na !== 1 || frame_num !== 2'd2) begin
            errors++;
            $display("FAIL resume_adv: got adv %0d frame %0d want 1/2",
                     na, frame_num);
        end
    endtask

    task automatic test_hold_lower();
        int ns, na, tot;
        int         eadv [7] = '{1, 0, 0, 1, 0, 0, 1};
        logic [1:0] efr  [7] = '{1, 1, 1, 2, 2, 2, 3};
        hold_cfg = 6'd20;
        do_reset();
        tot = 0;
        for (int i = 0; i < 15; i++) begin
            vframe(1, ns, na);
            tot += na;
        end
        checks++;
        if (tot !== 0) begin
            errors++;
            $display("FAIL h20_noadv: got adv %0d want 0", tot);
        end
        hold_cfg = 6'd3;
        settle(6);
        for (int i = 0; i < 7; i++) begin
            vframe(1, ns, na);
            checks++;
            if (na !== eadv[i] || frame_num !== efr[i]) begin
                errors++;
                $display("FAIL hlow f%0d: got %0d/%0d want %0d/%0d",
                         i, na, frame_num, eadv[i], efr[i]);
            end
        end
    endtask

    task automatic test_origin_ena();
        int ns, na;
        hold_cfg = 6'd1;
        do_reset();
        vframe(5, ns, na);
        checks++;
        if (ns !== 1 || na !== 1 || frame_num !== 2'd1) begin
            errors++;
            $display("FAIL long_origin: got sof %0d adv %0d frame %0d",
                     ns, na, frame_num);
        end
        ena = 1'b0;
        vframe(1, ns, na);
        checks++;
        if (ns !== 0 || na !== 0 || frame_num !== 2'd1) begin
            errors++;
            $display("FAIL ena_off: got sof %0d adv %0d frame %0d",
                     ns, na, frame_num);
        end
        ns = 0;
        na = 0;
        pix_x = 10'd0;
        pix_y = 10'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sof) ns++;
            if (frame_adv) na++;
            if (i == 2) ena = 1'b1;
            if (i == 4) begin
                pix_x = 10'd3;
                pix_y = 10'd9;
            end
        end
        checks++;
        if (ns !== 0 || na !== 0 || frame_num !== 2'd1) begin
            errors++;
            $display("FAIL reena_mid: got sof %0d adv %0d frame %0d",
                     ns, na, frame_num);
        end
        vframe(1, ns, na);
        checks++;
        if (ns !== 1 || na !== 1 || frame_num !== 2'd2) begin
            errors++;
            $display("FAIL reena_next: got sof %0d adv %0d frame %0d",
                     ns, na, frame_num);
        end
    endtask

    task automatic test_reset_mid();
        int ns, na, tot;
        hold_cfg = 6'd3;
        pingpong = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) vframe(1, ns, na);
        checks++;
        if (frame_num !== 2'd2 || dir !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst: got %0d/%b want 2/1", frame_num, dir);
        end
        pix_x = 10'd50;
        pix_y = 10'd20;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({frame_num, dir, frame_adv, sof} !== 5'b0) begin
            errors++;
            $display("FAIL async_rst: got %b want 00000",
                     {frame_num, dir, frame_adv, sof});
        end
        settle(2);
        rst_n = 1'b1;
        settle(6);
        tot = 0;
        for (int i = 0; i < 2; i++) begin
            vframe(1, ns, na);
            tot += na;
        end
        checks++;
        if (tot !== 0 || frame_num !== 2'd0) begin
            errors++;
            $display("FAIL post_rst_early: got adv %0d frame %0d",
                     tot, frame_num);
        end
        vframe(1, ns, na);
        checks++;
        if (na !== 1 || frame_num !== 2'd1 || dir !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_adv: got %0d/%0d/%b want 1/1/0",
                     na, frame_num, dir);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        pix_x    = 10'd5;
        pix_y    = 10'd5;
        hold_cfg = 6'd0;
        pingpong = 1'b0;
        pause    = 1'b0;
        step_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_pingpong();
        test_pause_step();
        test_hold_lower();
        test_origin_ena();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/anim_frame_sequencer.md
Name: anim_frame_sequencer

Overview:
- Upstream control stage for the goose sprite renderer: produces the animation frame index that selects which stored sprite frame the pixel pipeline displays.
- Detects start-of-frame from the VGA timing counters and holds each animation frame for a programmable number of video frames.
- Supports forward-wrap and ping-pong sequencing, pause, and single-step. Control inputs come from raw `ui_in` pins, so they are synchronised internally.

Parameters:
- NUM_FRAMES, 4: number of animation frames; legal range 2..2^FRAME_W.
- FRAME_W, 2: width of the frame index.
- CNT_W, 6: width of the hold counter and `hold_cfg`.
- DEFAULT_HOLD, 10: video frames per animation frame when `hold_cfg` == 0; legal range 1..2^CNT_W-1.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  1 = run; 0 = freeze all sequencing state (synchronisers keep running)
- pix_x  in  10  current horizontal pixel position from the timing generator
- pix_y  in  10  current vertical pixel position from the timing generator
- hold_cfg  in  CNT_W  video frames per animation frame; 0 selects DEFAULT_HOLD (asynchronous pins)
- pingpong  in  1  1 = ping-pong sequencing, 0 = forward wrap (asynchronous pin)
- pause  in  1  1 = halt automatic advance (asynchronous pin)
- step_req  in  1  a rising edge requests one frame advance while paused (asynchronous pin)
- frame_num  out  FRAME_W  current animation frame index
- frame_adv  out  1  one-cycle pulse in the cycle `frame_num` takes a new value
- dir  out  1  current direction: 0 = up, 1 = down
- sof  out  1  registered one-cycle start-of-frame pulse

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: frame_num=0, dir=0, frame_adv=0, sof=0, hold counter=0, step_pending=0, all synchroniser flops=0, state=RUN.
- Synchronisers: `pause`, `step_req`, `pingpong` each pass through a 2-flop synchroniser. `hold_cfg` bits are each double-flopped.
  - A glitch during a `hold_cfg` change may give one bad compare; this is acceptable.
  - Step edge = synced step_req is 1 and its previous registered value is 0.
- SOF detection:
  - at_origin = (pix_x==0 && pix_y==0).
  - `sof` is asserted the cycle after the first cycle of at_origin, i.e. gated by the registered previous at_origin. It fires exactly once per video frame even if the origin persists for several cycles.
- Effective hold: H = (hold_cfg_sync==0) ? DEFAULT_HOLD : hold_cfg_sync.
- State RUN (pause_sync=0):
  - On `sof`, if cnt >= H-1: cnt<=0 and advance. Otherwise cnt<=cnt+1.
  - The ">=" compare ensures prompt recovery when H is lowered below the current cnt.
  - step_pending is cleared in RUN; step edges are ignored.
- State PAUSED (pause_sync=1):
  - cnt is frozen and there is no automatic advance.
  - A step edge sets step_pending.
  - On `sof` with step_pending=1: advance, cnt<=0, step_pending<=0.
  - Multiple step edges before one `sof` produce a single advance.
- Transitions:
  - RUN→PAUSED when pause_sync=1.
  - PAUSED→RUN when pause_sync=0; cnt resumes from its held value.
  - Both transitions take effect in the cycle after pause_sync changes.
- Advance rule, forward (pingpong_sync=0):
  - frame_num <= (frame_num==NUM_FRAMES-1) ? 0 : frame_num+1.
  - dir<=0.
  - When pingpong_sync=0, dir is also forced to 0 on every cycle, not only on advance.
- Advance rule, ping-pong (pingpong_sync=1):
  - Going up (dir=0) at NUM_FRAMES-1: next frame is NUM_FRAMES-2, dir<=1.
  - Going down (dir=1) at 0: next frame is 1, dir<=0.
  - Otherwise ±1 per dir.
  - With NUM_FRAMES=2 the sequence is 0,1,0,1.
  - If frame_num is ever >= NUM_FRAMES (only possible with a non-power-of-2 NUM_FRAMES after a fault), the next advance goes to 0.
- Outputs:
  - `frame_adv` is registered and is high in the same cycle the new `frame_num` is visible.
  - Latency from at_origin to the `frame_num` change is 2 cycles.
- ena=0:
  - cnt, frame_num, dir, step_pending and state hold.
  - `sof` and `frame_adv` are forced to 0.
  - The registered previous at_origin still tracks, so re-enabling mid-frame does not spuriously fire `sof`.
- Reset mid-operation: all state returns to reset values immediately. The first advance after release requires H full `sof` pulses.

Test Plan:
- Reset values: reset, then hold_cfg=0, pingpong=0, pause=0, and run 45 video frames → frame_adv fires on the 10th, 20th, 30th and 40th `sof`; frame_num sequence 0,1,2,3,0; dir stays 0.
- Ping-pong: hold_cfg=2, pingpong=1 held high → frame_num changes every 2 `sof` pulses: 0,1,2,3,2,1,0,1. dir=1 exactly during the 3→2→1→0 leg.
- Pause and step: pause=1 with cnt=4, then three step_req pulses within one frame → exactly one advance at the next `sof` with cnt=0. With no step pulses, 20 frames pass with no advance. Release pause → the next advance comes H `sof` pulses later.
- Hold lowered mid-count: hold_cfg=20 and wait until cnt=15, then set hold_cfg=3 → advance on the next `sof`, then every 3 `sof` pulses.
- Origin held for 5 clocks → `sof` pulses exactly once. With ena=0 across a frame, no `sof` or `frame_adv` occurs and frame_num is unchanged.
- Reset mid-operation: assert rst_n low mid-frame at frame_num=2, dir=1 → outputs are 0 asynchronously (same cycle); after release, first advance to 1 occurs on the H-th `sof`.
